// File: rtl/scan_decoder_if.sv
// Bundle of control inputs and registered decode outputs for scan_decoder.
// Latency: none; signal container only.
// Backpressure: none; the decoder accepts control inputs on every clock.
interface scan_decoder_if #(
    parameter int N = 3
);
    localparam int OUTS = 2 ** N;

    logic            en;
    logic            mode;
    logic            load;
    logic [N-1:0]    x;
    logic [OUTS-1:0] D;
    logic [N-1:0]    idx;
    logic            wrap;

    // Controller side: drives the select and mode, observes the decode.
    modport master (
        output en,
        output mode,
        output load,
        output x,
        input  D,
        input  idx,
        input  wrap
    );

    // Decoder side.
    modport slave (
        input  en,
        input  mode,
        input  load,
        input  x,
        output D,
        output idx,
        output wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// N-to-2^N one-hot decoder with enable, plus an auto-scan sequencer (dwell/blank).
// Latency: one clock from any input change to D/idx/wrap; all outputs registered.
// Backpressure: none; the decoder accepts control inputs on every clock.
module scan_decoder #(
    parameter int N     = 3,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    scan_decoder_if.slave bus
);
    localparam int OUTS = 2 ** N;

    // The counter must reach both DWELL-1 and BLANK-1, and is never narrower than one bit.
    localparam int CMAX = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                          : ((BLANK > 2) ? BLANK : 2);
    localparam int CW   = $clog2(CMAX);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    // With no blanking, the GAP state is unreachable; its terminal count is a don't-care.
    localparam logic [CW-1:0] GAP_LAST   = (BLANK > 0) ? CW'(BLANK - 1) : '0;
    localparam bit            HAS_GAP    = (BLANK > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state;
    logic [OUTS-1:0] d_q;
    logic [N-1:0]    idx_q;
    logic            wrap_q;
    logic [CW-1:0]   cnt;

    // Next scan index wraps naturally in N bits, i.e. modulo OUTS.
    logic [N-1:0] idx_inc;
    logic         idx_last;

    assign idx_inc  = idx_q + N'(1);
    assign idx_last = (idx_q == {N{1'b1}});

    function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] sel);
        logic [OUTS-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // Sequencer: priority is reset, enable, mode, load, then dwell/gap sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            d_q    <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            cnt    <= '0;
        end else if (!bus.en) begin
            // Blank everything but keep idx so a later scan resumes where it stopped.
            state  <= IDLE;
            d_q    <= '0;
            wrap_q <= 1'b0;
            cnt    <= '0;
        end else if (!bus.mode) begin
            // Manual decode; any scan position is discarded.
            state  <= MAN;
            idx_q  <= bus.x;
            d_q    <= onehot(bus.x);
            wrap_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, MAN: begin
                    // Entering auto mode resumes at the held index; load is not honoured here.
                    state  <= SCAN;
                    d_q    <= onehot(idx_q);
                    wrap_q <= 1'b0;
                    cnt    <= '0;
                end
                SCAN, GAP: begin
                    if (bus.load) begin
                        // Jump and restart the dwell; a jump to 0 is not a wrap.
                        state  <= SCAN;
                        idx_q  <= bus.x;
                        d_q    <= onehot(bus.x);
                        wrap_q <= 1'b0;
                        cnt    <= '0;
                    end else if (state == SCAN) begin
                        if (cnt == DWELL_LAST) begin
                            if (HAS_GAP) begin
                                state  <= GAP;
                                d_q    <= '0;
                                wrap_q <= 1'b0;
                                cnt    <= '0;
                            end else begin
                                state  <= SCAN;
                                idx_q  <= idx_inc;
                                d_q    <= onehot(idx_inc);
                                wrap_q <= idx_last;
                                cnt    <= '0;
                            end
                        end else begin
                            wrap_q <= 1'b0;
                            cnt    <= cnt + CW'(1);
                        end
                    end else begin
                        if (cnt == GAP_LAST) begin
                            state  <= SCAN;
                            idx_q  <= idx_inc;
                            d_q    <= onehot(idx_inc);
                            wrap_q <= idx_last;
                            cnt    <= '0;
                        end else begin
                            wrap_q <= 1'b0;
                            cnt    <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    d_q    <= '0;
                    wrap_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.D    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: default config (N=3, DWELL=4, BLANK=1) and corner config (N=2, DWELL=1, BLANK=0).
// Latency: reference model advances at each rising edge; outputs compared on the falling edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_scan_decoder;
    logic clk = 1'b0;
    logic rst_n;

    // Free-running clock.
    always #5 clk = ~clk;

    logic       en_v   [2];
    logic       mode_v [2];
    logic       load_v [2];
    logic [2:0] x_v    [2];

    scan_decoder_if #(.N(3)) bus_a ();
    scan_decoder_if #(.N(2)) bus_b ();

    assign bus_a.en   = en_v[0];
    assign bus_a.mode = mode_v[0];
    assign bus_a.load = load_v[0];
    assign bus_a.x    = x_v[0];
    assign bus_b.en   = en_v[1];
    assign bus_b.mode = mode_v[1];
    assign bus_b.load = load_v[1];
    assign bus_b.x    = x_v[1][1:0];

    scan_decoder #(.N(3), .DWELL(4), .BLANK(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    scan_decoder #(.N(2), .DWELL(1), .BLANK(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: an output is either off, a manual decode, or an auto scan
    // described by its start index and the cycles elapsed since the scan (re)started.
    int cfg_n  [2] = '{3, 2};
    int cfg_dw [2] = '{4, 1};
    int cfg_bl [2] = '{1, 0};
    int kind   [2];  // 0 = off, 1 = manual, 2 = auto
    int hidx   [2];
    int base   [2];
    int tt     [2];

    function automatic int m_outs(int d);
        return 1 << cfg_n[d];
    endfunction

    function automatic int m_per(int d);
        return cfg_dw[d] + cfg_bl[d];
    endfunction

    function automatic int m_idx(int d);
        if (kind[d] == 2) return (base[d] + tt[d] / m_per(d)) % m_outs(d);
        return hidx[d];
    endfunction

    function automatic int m_D(int d);
        if (kind[d] == 0) return 0;
        if (kind[d] == 1) return 1 << hidx[d];
        if ((tt[d] % m_per(d)) < cfg_dw[d]) return 1 << m_idx(d);
        return 0;
    endfunction

    function automatic int m_wrap(int d);
        if (kind[d] == 2 && (tt[d] % m_per(d)) == 0 && (tt[d] / m_per(d)) > 0 && m_idx(d) == 0)
            return 1;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int d);
        int xi;
        xi = int'(x_v[d]) % m_outs(d);
        if (!rst_n) begin
            kind[d] = 0;
            hidx[d] = 0;
        end else if (!en_v[d]) begin
            hidx[d] = m_idx(d);
            kind[d] = 0;
        end else if (!mode_v[d]) begin
            kind[d] = 1;
            hidx[d] = xi;
        end else if (kind[d] != 2) begin
            base[d] = hidx[d];
            tt[d]   = 0;
            kind[d] = 2;
        end else if (load_v[d]) begin
            base[d] = xi;
            tt[d]   = 0;
        end else begin
            tt[d]   = tt[d] + 1;
        end
    endtask

    task automatic compare_all();
        check("D_a",    32'(bus_a.D),    m_D(0));
        check("idx_a",  32'(bus_a.idx),  m_idx(0));
        check("wrap_a", 32'(bus_a.wrap), m_wrap(0));
        check("D_b",    32'(bus_b.D),    m_D(1));
        check("idx_b",  32'(bus_b.idx),  m_idx(1));
        check("wrap_b", 32'(bus_b.wrap), m_wrap(1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic drive(input int d, input logic e, input logic m, input logic l, input logic [2:0] xx);
        en_v[d]   = e;
        mode_v[d] = m;
        load_v[d] = l;
        x_v[d]    = xx;
    endtask

    // Directed scenarios followed by a randomized soak, all against the model.
    initial begin
        int s;
        int wraps_b;
        int wq[$];

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        check("rst_D",    32'(bus_a.D),    32'h0);
        check("rst_idx",  32'(bus_a.idx),  32'h0);
        check("rst_wrap", 32'(bus_a.wrap), 32'h0);

        // Manual decode.
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 3'd5);
        drive(1, 1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        check("man5_D",   32'(bus_a.D),   32'h20);
        check("man5_idx", 32'(bus_a.idx), 32'd5);
        drive(0, 1'b1, 1'b0, 1'b0, 3'd7);
        tick();
        check("man7_D", 32'(bus_a.D), 32'h80);

        // Enable gating.
        drive(0, 1'b1, 1'b0, 1'b0, 3'd3);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 3'd3);
        tick();
        check("en0_D",   32'(bus_a.D),   32'h00);
        check("en0_idx", 32'(bus_a.idx), 32'd3);
        drive(0, 1'b1, 1'b0, 1'b0, 3'd3);
        tick();
        check("en1_D", 32'(bus_a.D), 32'h08);

        // Auto scan from index 0 on both decoders.
        drive(0, 1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 3'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        s = cyc;
        check("scan0_D", 32'(bus_a.D), 32'h01);
        wraps_b = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (bus_a.wrap) wq.push_back(cyc);
            if (bus_b.wrap) wraps_b++;
        end
        check("wrap_a_count", 32'(wq.size()), 32'd2);
        if (wq.size() >= 2) begin
            check("frame_first", 32'(wq[0] - s), 32'd40);
            check("frame_len",   32'(wq[1] - wq[0]), 32'd40);
        end
        check("wrap_b_count", 32'(wraps_b), 32'd22);

        // Scan is now at idx 2, dwell counter 0; one more cycle puts it at counter 1.
        tick();
        check("pre_load_D", 32'(bus_a.D), 32'h04);
        drive(0, 1'b1, 1'b1, 1'b1, 3'd6);
        tick();
        check("load_D",    32'(bus_a.D),    32'h40);
        check("load_idx",  32'(bus_a.idx),  32'd6);
        check("load_wrap", 32'(bus_a.wrap), 32'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 3'd6);
        for (int i = 0; i < 4; i++) tick();
        check("gap_D", 32'(bus_a.D), 32'h00);
        drive(0, 1'b1, 1'b1, 1'b1, 3'd6);
        tick();
        check("gap_load_D", 32'(bus_a.D), 32'h40);
        drive(0, 1'b1, 1'b1, 1'b0, 3'd6);
        for (int i = 0; i < 4; i++) tick();

        // Mode change out of GAP, then reset from SCAN.
        drive(0, 1'b1, 1'b0, 1'b0, 3'd1);
        tick();
        check("gap_man_D", 32'(bus_a.D), 32'h02);
        drive(0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("scan_rst_D",    32'(bus_a.D),    32'h0);
        check("scan_rst_idx",  32'(bus_a.idx),  32'h0);
        check("scan_rst_wrap", 32'(bus_a.wrap), 32'h0);
        rst_n = 1'b1;

        // Randomized soak with sticky mode and occasional reset/disable/load.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(999) >= 5);
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(99) < 3) mode_v[d] = ~mode_v[d];
                en_v[d]   = ($urandom_range(99) < 92);
                load_v[d] = ($urandom_range(99) < 6);
                x_v[d]    = 3'($urandom);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
